ring_frame_reader: RTL and testbench

- Downstream consumer of the audio ring buffer.
- On a start pulse, drains one analysis window of WINDOW samples from the ring buffer by issuing read triggers.
- Re-emits the samples as a valid/ready stream with first/last framing, and reports the frame energy (sum of squares).
- Feeds the pitch-detection stage. Handles downstream backpressure with a credit-limited internal FIFO.

---
 rtl/audio_pkg.sv | 10 +
 rtl/stream_fifo.sv | 66 ++++++
 rtl/ring_frame_reader.sv | 171 +++++++++++++++++
 tb/tb_ring_frame_reader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path types and sizing constants.
package audio_pkg;

    localparam int unsigned SAMPLE_WIDTH   = 16;
    // Ring buffer entry count and analysis window length both derive from this.
    localparam int unsigned WINDOW_DEFAULT = 2048;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO; read data is taken directly from the storage flops at the read pointer.
module stream_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 18,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             wr_en_in,
    input  logic [WIDTH-1:0] wr_data_in,
    input  logic             rd_en_in,
    output logic [WIDTH-1:0] rd_data_out,
    output logic             full_out,
    output logic             empty_out,
    output logic [CW-1:0]    count_out
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    assign full_out    = (count_q == CW'(DEPTH));
    assign empty_out   = (count_q == '0);
    assign count_out   = count_q;
    assign rd_data_out = mem_q[rd_ptr_q];
    // Writes into a full FIFO and reads from an empty one are ignored.
    assign do_wr       = wr_en_in && !full_out;
    assign do_rd       = rd_en_in && !empty_out;

    // Next-state for storage, pointers (wrapping at DEPTH) and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data_in;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(do_wr) - CW'(do_rd);
    end

    // State registers with asynchronous clear of contents as well as pointers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ring_frame_reader.sv
// Drains one analysis window from the audio ring buffer, re-emits it as a framed
// valid/ready stream and reports the frame energy (sum of squares).
module ring_frame_reader
    import audio_pkg::*;
#(
    parameter int unsigned WINDOW       = WINDOW_DEFAULT,
    parameter int unsigned DATA_WIDTH   = SAMPLE_WIDTH,
    parameter int unsigned FIFO_DEPTH   = 4,
    localparam int unsigned ENERGY_WIDTH = 2 * DATA_WIDTH + $clog2(WINDOW + 1)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start_in,
    output logic                    busy_out,
    output logic                    read_trigger_out,
    input  logic [DATA_WIDTH-1:0]   rb_data_in,
    input  logic                    rb_valid_in,
    output logic [DATA_WIDTH-1:0]   sample_out,
    output logic                    sample_valid_out,
    input  logic                    sample_ready_in,
    output logic                    sample_first_out,
    output logic                    sample_last_out,
    output logic [ENERGY_WIDTH-1:0] energy_out,
    output logic                    energy_valid_out,
    output logic                    overrun_out,
    output logic                    err_out
);

    localparam int unsigned IW = $clog2(WINDOW + 1);
    localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FW = DATA_WIDTH + 2;

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e                  state_q, state_d;
    logic [IW-1:0]           issued_q, issued_d;
    logic [IW-1:0]           out_idx_q, out_idx_d;
    logic [OW-1:0]           outstanding_q, outstanding_d;
    logic                    inflight_q, inflight_d;
    logic [ENERGY_WIDTH-1:0] acc_q, acc_d;
    logic [ENERGY_WIDTH-1:0] energy_q, energy_d;
    logic                    energy_valid_q, energy_valid_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;
    logic                    err_q, err_d;

    logic                    fifo_wr, fifo_full, fifo_empty, handshake;
    logic [FW-1:0]           fifo_wr_data, fifo_head;
    logic [OW-1:0]           unused_fifo_count;
    logic [2*DATA_WIDTH-1:0] rb_ext, sq;

    // Square taken modulo 2^(2*DATA_WIDTH): the true square is below 2^(2*DATA_WIDTH-1),
    // so the low bits of the sign-extended product are exact and non-negative.
    assign rb_ext = {{DATA_WIDTH{rb_data_in[DATA_WIDTH-1]}}, rb_data_in};
    assign sq     = rb_ext * rb_ext;

    assign read_trigger_out = (state_q == StFetch) && (issued_q < IW'(WINDOW))
                              && (outstanding_q < OW'(FIFO_DEPTH));
    assign fifo_wr          = rb_valid_in && !fifo_full;
    assign fifo_wr_data     = {(out_idx_q == '0), (out_idx_q == IW'(WINDOW - 1)), rb_data_in};
    assign sample_valid_out = !fifo_empty;
    assign handshake        = sample_valid_out && sample_ready_in;
    assign sample_out       = fifo_head[DATA_WIDTH-1:0];
    assign sample_first_out = sample_valid_out && fifo_head[DATA_WIDTH+1];
    assign sample_last_out  = sample_valid_out && fifo_head[DATA_WIDTH];

    assign busy_out         = busy_q;
    assign energy_out       = energy_q;
    assign energy_valid_out = energy_valid_q;
    assign overrun_out      = overrun_q;
    assign err_out          = err_q;

    stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .wr_en_in    (fifo_wr),
        .wr_data_in  (fifo_wr_data),
        .rd_en_in    (handshake),
        .rd_data_out (fifo_head),
        .full_out    (fifo_full),
        .empty_out   (fifo_empty),
        .count_out   (unused_fifo_count)
    );

    // Next-state: capture/accumulate, credit tracking, then the frame FSM.
    always_comb begin
        state_d        = state_q;
        issued_d       = issued_q + IW'(read_trigger_out);
        acc_d          = acc_q;
        out_idx_d      = out_idx_q;
        outstanding_d  = outstanding_q;
        inflight_d     = read_trigger_out;
        energy_d       = energy_q;
        energy_valid_d = 1'b0;
        busy_d         = busy_q;
        overrun_d      = start_in && (state_q != StIdle);
        // A sample with no read in flight, or with nowhere to go, is a protocol error.
        err_d          = err_q || (rb_valid_in && (!inflight_q || fifo_full));

        if (fifo_wr) begin
            acc_d     = acc_q + ENERGY_WIDTH'(sq);
            out_idx_d = (out_idx_q == IW'(WINDOW - 1)) ? '0 : out_idx_q + IW'(1);
        end

        case ({read_trigger_out, handshake})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        case (state_q)
            StIdle: begin
                if (start_in) begin
                    state_d   = StFetch;
                    busy_d    = 1'b1;
                    issued_d  = '0;
                    acc_d     = '0;
                    out_idx_d = '0;
                end
            end
            StFetch: begin
                if (issued_d == IW'(WINDOW)) state_d = StDrain;
            end
            StDrain: begin
                if (handshake && sample_last_out) begin
                    state_d        = StDone;
                    energy_d       = acc_d;
                    energy_valid_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Single state register for the FSM, counters and all registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= StIdle;
            issued_q       <= '0;
            out_idx_q      <= '0;
            outstanding_q  <= '0;
            inflight_q     <= 1'b0;
            acc_q          <= '0;
            energy_q       <= '0;
            energy_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            issued_q       <= issued_d;
            out_idx_q      <= out_idx_d;
            outstanding_q  <= outstanding_d;
            inflight_q     <= inflight_d;
            acc_q          <= acc_d;
            energy_q       <= energy_d;
            energy_valid_q <= energy_valid_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            err_q          <= err_d;
        end
    end

endmodule

// File: tb/tb_ring_frame_reader.sv
// Directed bench for ring_frame_reader with an 8-sample window and a simple ring buffer model.
module tb_ring_frame_reader;

    localparam int unsigned W  = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned FD = 4;
    localparam int unsigned EW = 2 * DW + $clog2(W + 1);

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic          busy_out;
    logic          read_trigger_out;
    logic [DW-1:0] rb_data_in;
    logic          rb_valid_in;
    logic [DW-1:0] sample_out;
    logic          sample_valid_out;
    logic          sample_ready_in;
    logic          sample_first_out;
    logic          sample_last_out;
    logic [EW-1:0] energy_out;
    logic          energy_valid_out;
    logic          overrun_out;
    logic          err_out;

    logic [DW-1:0] mem [W];
    int            rd_ptr;
    logic          inject;
    logic [DW-1:0] inject_data;

    int checks = 0;
    int errors = 0;
    int ntrig;

    ring_frame_reader #(
        .WINDOW     (W),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .start_in         (start_in),
        .busy_out         (busy_out),
        .read_trigger_out (read_trigger_out),
        .rb_data_in       (rb_data_in),
        .rb_valid_in      (rb_valid_in),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out),
        .sample_ready_in  (sample_ready_in),
        .sample_first_out (sample_first_out),
        .sample_last_out  (sample_last_out),
        .energy_out       (energy_out),
        .energy_valid_out (energy_valid_out),
        .overrun_out      (overrun_out),
        .err_out          (err_out)
    );

    always #5 clk_in = ~clk_in;

    // Ring buffer: data returns one cycle after each trigger; inject forces a stray valid.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rb_valid_in <= 1'b0;
            rb_data_in  <= '0;
            rd_ptr      <= 0;
        end else begin
            if (start_in && !busy_out) rd_ptr <= 0;
            else if (read_trigger_out) rd_ptr <= rd_ptr + 1;
            rb_valid_in <= read_trigger_out | inject;
            rb_data_in  <= read_trigger_out ? mem[rd_ptr % W] : inject_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges and land 1 time unit after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Start is sampled at the next edge (edge 0); returns in cycle 1.
    task automatic start_frame();
        start_in = 1'b1;
        cyc(1);
        start_in = 1'b0;
    endtask

    // Follows a frame to its energy pulse, checking order, framing and energy.
    task automatic run_frame(input string tag, input logic [EW-1:0] exp_e);
        int  n    = 0;
        bit  done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (sample_valid_out && sample_ready_in) begin
                if (n < int'(W)) begin
                    chk({tag, "_data"}, 64'(sample_out), 64'(mem[n]));
                    chk({tag, "_first"}, 64'(sample_first_out), 64'(n == 0));
                    chk({tag, "_last"}, 64'(sample_last_out), 64'(n == int'(W) - 1));
                end else begin
                    chk({tag, "_extra_sample"}, 64'(n), 64'(W - 1));
                end
                n++;
            end
            if (energy_valid_out) begin
                chk({tag, "_count"}, 64'(n), 64'(W));
                chk({tag, "_energy"}, 64'(energy_out), 64'(exp_e));
                done = 1;
            end else begin
                cyc(1);
            end
        end
        if (!done) chk({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    initial begin
        rst_in          = 1'b1;
        start_in        = 1'b0;
        sample_ready_in = 1'b1;
        inject          = 1'b0;
        inject_data     = '0;
        for (int i = 0; i < int'(W); i++) mem[i] = DW'(i + 1);
        cyc(2);
        chk("rst_busy", 64'(busy_out), 64'(0));
        chk("rst_trig", 64'(read_trigger_out), 64'(0));
        chk("rst_valid", 64'(sample_valid_out), 64'(0));
        chk("rst_energy", 64'(energy_out), 64'(0));
        chk("rst_err", 64'(err_out), 64'(0));
        rst_in = 1'b0;
        cyc(1);

        // 1: samples 1..8 with ready high, cycle-exact timing; energy 204.
        start_frame();
        for (int c = 1; c <= 12; c++) begin
            chk("t1_trig", 64'(read_trigger_out), 64'(c <= 8));
            chk("t1_busy", 64'(busy_out), 64'(c <= 11));
            if (c >= 3 && c <= 10) begin
                chk("t1_valid", 64'(sample_valid_out), 64'(1));
                chk("t1_data", 64'(sample_out), 64'(c - 2));
                chk("t1_first", 64'(sample_first_out), 64'(c == 3));
                chk("t1_last", 64'(sample_last_out), 64'(c == 10));
            end else begin
                chk("t1_valid_idle", 64'(sample_valid_out), 64'(0));
            end
            chk("t1_evalid", 64'(energy_valid_out), 64'(c == 11));
            if (c == 11) chk("t1_energy", 64'(energy_out), 64'd204);
            cyc(1);
        end

        // 2: full-scale alternating samples; 4*2^30 + 4*32767^2.
        for (int i = 0; i < int'(W); i++) mem[i] = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
        start_frame();
        run_frame("t2", EW'(64'd8589672452));
        chk("t2_energy_hold", 64'(energy_out), 64'd8589672452);
        cyc(2);

        // 3: ready low for 20 cycles: four reads then stall with the first sample held.
        for (int i = 0; i < int'(W); i++) mem[i] = DW'(100 + i);
        sample_ready_in = 1'b0;
        ntrig = 0;
        start_frame();
        for (int c = 1; c <= 20; c++) begin
            if (read_trigger_out) ntrig++;
            if (c == 6) begin
                chk("t3_hold_valid", 64'(sample_valid_out), 64'(1));
                chk("t3_hold_data", 64'(sample_out), 64'd100);
            end
            cyc(1);
        end
        chk("t3_trig_count", 64'(ntrig), 64'(FD));
        chk("t3_valid", 64'(sample_valid_out), 64'(1));
        chk("t3_data", 64'(sample_out), 64'd100);
        chk("t3_first", 64'(sample_first_out), 64'(1));
        sample_ready_in = 1'b1;
        run_frame("t3", EW'(85740));
        cyc(2);

        // 4: second start mid-FETCH is ignored and reported once.
        for (int i = 0; i < int'(W); i++) mem[i] = DW'(i + 1);
        start_frame();
        start_in = 1'b1;
        cyc(1);
        start_in = 1'b0;
        chk("t4_overrun", 64'(overrun_out), 64'(1));
        cyc(1);
        chk("t4_overrun_pulse", 64'(overrun_out), 64'(0));
        run_frame("t4", EW'(204));
        cyc(1);
        chk("t4_idle", 64'(busy_out), 64'(0));
        start_frame();
        chk("t4_restart_busy", 64'(busy_out), 64'(1));
        run_frame("t4b", EW'(204));
        cyc(2);

        // 5: asynchronous reset mid-DRAIN abandons the frame.
        start_frame();
        cyc(8);
        chk("t5_pre_valid", 64'(sample_valid_out), 64'(1));
        #2;
        rst_in = 1'b1;
        #1;
        chk("t5_busy", 64'(busy_out), 64'(0));
        chk("t5_trig", 64'(read_trigger_out), 64'(0));
        chk("t5_valid", 64'(sample_valid_out), 64'(0));
        chk("t5_first_last", 64'({sample_first_out, sample_last_out}), 64'(0));
        chk("t5_energy", 64'(energy_out), 64'(0));
        chk("t5_evalid", 64'(energy_valid_out), 64'(0));
        cyc(1);
        rst_in = 1'b0;
        ntrig = 0;
        for (int c = 0; c < 12; c++) begin
            if (energy_valid_out) ntrig++;
            cyc(1);
        end
        chk("t5_no_energy_pulse", 64'(ntrig), 64'(0));
        start_frame();
        run_frame("t5", EW'(204));
        cyc(2);

        // 6: stray rb_valid with no read in flight sets a sticky error.
        chk("t6_err_before", 64'(err_out), 64'(0));
        inject      = 1'b1;
        inject_data = 16'd5;
        cyc(1);
        inject = 1'b0;
        chk("t6_err_capture_cycle", 64'(err_out), 64'(0));
        cyc(1);
        chk("t6_err_set", 64'(err_out), 64'(1));
        cyc(6);
        chk("t6_err_sticky", 64'(err_out), 64'(1));
        rst_in = 1'b1;
        cyc(1);
        rst_in = 1'b0;
        chk("t6_err_cleared", 64'(err_out), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
